// File: rtl/dll_code_tracker.sv
// DLL power-up sequencing, lock filtering and delay-code capture, with staggered
// per-lane distribution and rate-limited drift-driven code updates.
module dll_code_tracker #(
    parameter int CODE_WIDTH    = 8,
    parameter int NUM_LANES     = 4,
    parameter int LOCK_FILTER   = 8,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 16,
    parameter int HYST          = 2,
    parameter int UPDATE_GAP    = 64
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic                            ENABLE,
    input  logic                            FORCE_UPDATE,
    input  logic                            CLEAR_STATUS,
    input  logic                            DLL_LOCK,
    input  logic                            DLL_DELAY_DIFF,
    input  logic [CODE_WIDTH-1:0]           DLL_CODE,
    output logic                            DLL_POWERDOWN_N,
    output logic                            DLL_CODE_UPDATE,
    output logic [NUM_LANES*CODE_WIDTH-1:0] LANE_CODE,
    output logic [NUM_LANES-1:0]            LANE_LOAD,
    output logic                            LOCKED,
    output logic                            LOCK_LOST,
    output logic                            LOCK_FAIL,
    output logic [15:0]                     UPDATE_COUNT,
    output logic [2:0]                      STATE
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] POWERUP    = 3'd1;
    localparam logic [2:0] SAMPLE     = 3'd2;
    localparam logic [2:0] DISTRIBUTE = 3'd3;
    localparam logic [2:0] TRACK      = 3'd4;
    localparam logic [2:0] UPDATE     = 3'd5;

    localparam int LIW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int LKW = $clog2(LOCK_FILTER + 1);
    localparam int PUW = $clog2(LOCK_TIMEOUT + 1);
    localparam int STW = $clog2(STABLE_CYCLES + 1);
    localparam int GPW = $clog2(UPDATE_GAP + 1);

    localparam logic [LIW-1:0]        LANE_LAST = LIW'(NUM_LANES - 1);
    localparam logic [LKW-1:0]        LK_MAX    = LKW'(LOCK_FILTER);
    localparam logic [PUW-1:0]        PU_LAST   = PUW'(LOCK_TIMEOUT - 1);
    localparam logic [STW-1:0]        ST_LAST   = STW'(STABLE_CYCLES - 1);
    localparam logic [STW-1:0]        ST_MAX    = STW'(STABLE_CYCLES);
    localparam logic [GPW-1:0]        GAP_MAX   = GPW'(UPDATE_GAP);
    localparam logic [CODE_WIDTH:0]   HYST_C    = (CODE_WIDTH + 1)'(HYST);

    logic [2:0]            state;
    logic                  lk_meta, lk, lk_d;
    logic                  dd_meta, dd;
    logic [LKW-1:0]        lock_cnt;
    logic [PUW-1:0]        pu_cnt;
    logic [STW-1:0]        stab_cnt;
    logic [STW-1:0]        drift_cnt;
    logic [GPW-1:0]        gap_cnt;
    logic [LIW-1:0]        lane_idx;
    logic [CODE_WIDTH-1:0] cand;
    logic [CODE_WIDTH-1:0] held;
    logic [CODE_WIDTH:0]   drift;
    logic                  drift_hit;
    logic                  lock_loss;

    assign STATE = state;

    always_comb begin
        drift = '0;
        if (DLL_CODE >= held) drift = {1'b0, DLL_CODE - held};
        else                  drift = {1'b0, held - DLL_CODE};
    end

    assign drift_hit = (drift > HYST_C) || dd;
    // Lock loss needs two consecutive low synced samples while past POWERUP.
    assign lock_loss = !lk && !lk_d &&
                       (state == SAMPLE || state == DISTRIBUTE ||
                        state == TRACK  || state == UPDATE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state           <= IDLE;
            lk_meta         <= 1'b0;
            lk              <= 1'b0;
            lk_d            <= 1'b0;
            dd_meta         <= 1'b0;
            dd              <= 1'b0;
            lock_cnt        <= '0;
            pu_cnt          <= '0;
            stab_cnt        <= '0;
            drift_cnt       <= '0;
            gap_cnt         <= '0;
            lane_idx        <= '0;
            cand            <= '0;
            held            <= '0;
            DLL_POWERDOWN_N <= 1'b0;
            DLL_CODE_UPDATE <= 1'b0;
            LANE_CODE       <= '0;
            LANE_LOAD       <= '0;
            LOCKED          <= 1'b0;
            LOCK_LOST       <= 1'b0;
            LOCK_FAIL       <= 1'b0;
            UPDATE_COUNT    <= '0;
        end else begin
            lk_meta         <= DLL_LOCK;
            lk              <= lk_meta;
            lk_d            <= lk;
            dd_meta         <= DLL_DELAY_DIFF;
            dd              <= dd_meta;
            LANE_LOAD       <= '0;
            DLL_CODE_UPDATE <= 1'b0;

            // Set events below override a coincident clear.
            if (CLEAR_STATUS) begin
                LOCK_LOST <= 1'b0;
                LOCK_FAIL <= 1'b0;
            end

            if (!ENABLE) begin
                state           <= IDLE;
                LOCKED          <= 1'b0;
                DLL_POWERDOWN_N <= 1'b0;
            end else if (lock_loss) begin
                state    <= POWERUP;
                LOCKED   <= 1'b0;
                pu_cnt   <= '0;
                lock_cnt <= '0;
                if (LOCKED) LOCK_LOST <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state           <= POWERUP;
                        DLL_POWERDOWN_N <= 1'b1;
                        pu_cnt          <= '0;
                        lock_cnt        <= '0;
                    end
                    POWERUP: begin
                        if (lock_cnt == LK_MAX) begin
                            state    <= SAMPLE;
                            cand     <= DLL_CODE;
                            stab_cnt <= '0;
                        end else if (pu_cnt == PU_LAST) begin
                            state           <= IDLE;
                            LOCK_FAIL       <= 1'b1;
                            DLL_POWERDOWN_N <= 1'b0;
                        end else begin
                            pu_cnt   <= pu_cnt + PUW'(1);
                            lock_cnt <= lk ? lock_cnt + LKW'(1) : '0;
                        end
                    end
                    SAMPLE: begin
                        if (stab_cnt == ST_LAST) begin
                            held     <= cand;
                            lane_idx <= '0;
                            state    <= DISTRIBUTE;
                        end else if (DLL_CODE == cand) begin
                            stab_cnt <= stab_cnt + STW'(1);
                        end else begin
                            cand     <= DLL_CODE;
                            stab_cnt <= '0;
                        end
                    end
                    DISTRIBUTE: begin
                        LANE_CODE[int'(lane_idx)*CODE_WIDTH +: CODE_WIDTH] <= held;
                        LANE_LOAD <= NUM_LANES'(1) << lane_idx;
                        lane_idx  <= lane_idx + LIW'(1);
                        if (lane_idx == LANE_LAST) begin
                            if (UPDATE_COUNT != '1) UPDATE_COUNT <= UPDATE_COUNT + 16'd1;
                            LOCKED    <= 1'b1;
                            gap_cnt   <= '0;
                            drift_cnt <= '0;
                            state     <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (drift_hit) begin
                            if (drift_cnt != ST_MAX) drift_cnt <= drift_cnt + STW'(1);
                        end else begin
                            drift_cnt <= '0;
                        end
                        if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GPW'(1);
                        if (FORCE_UPDATE || (drift_cnt >= ST_MAX && gap_cnt == GAP_MAX)) begin
                            state           <= UPDATE;
                            DLL_CODE_UPDATE <= 1'b1;
                        end
                    end
                    UPDATE: begin
                        state    <= SAMPLE;
                        cand     <= DLL_CODE;
                        stab_cnt <= '0;
                    end
                    default: begin
                        state           <= IDLE;
                        DLL_POWERDOWN_N <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
